// File: rtl/ysyx_issue_sched.sv
// Oldest-first issue scheduler: one registered grant per execute port (ALU, LSU).
// Age is measured as ROB distance from the head. Memory ops leave in program order.
`ifndef YSYX_RS_SIZE
`define YSYX_RS_SIZE 8
`endif
`ifndef YSYX_ROB_SIZE
`define YSYX_ROB_SIZE 16
`endif

module ysyx_issue_sched #(
   parameter int RS_SIZE  = `YSYX_RS_SIZE,
   parameter int ROB_SIZE = `YSYX_ROB_SIZE,
   localparam int ROBW    = $clog2(ROB_SIZE),
   localparam int RSW     = $clog2(RS_SIZE)
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [RS_SIZE-1:0]      rs_busy,
   input  logic [RS_SIZE-1:0]      rs_ready,
   input  logic [RS_SIZE-1:0]      rs_is_mem,
   input  logic [RS_SIZE*ROBW-1:0] rs_rob_idx,
   input  logic [ROBW-1:0]         rob_head,
   input  logic                    flush,
   output logic                    alu_valid,
   output logic [RSW-1:0]          alu_idx,
   input  logic                    alu_ready,
   output logic                    lsu_valid,
   output logic [RSW-1:0]          lsu_idx,
   input  logic                    lsu_ready,
   output logic [RS_SIZE-1:0]      issue_ack,
   output logic                    out_idle
);

   // Wrap-around distance from the ROB head; smaller means older.
   logic [RS_SIZE-1:0][ROBW-1:0] age;

   for (genvar g = 0; g < RS_SIZE; g++) begin : g_age
      assign age[g] = rs_rob_idx[g*ROBW +: ROBW] - rob_head;
   end

   logic            alu_any, mem_any, lsu_any;
   logic [RSW-1:0]  alu_pick, mem_pick;
   logic [ROBW-1:0] alu_best, mem_best;
   logic            alu_load, lsu_load;

   // Oldest ready ALU entry; strict '<' keeps the lower index on equal age.
   always_comb begin
      alu_any  = 1'b0;
      alu_pick = '0;
      alu_best = '0;
      for (int i = 0; i < RS_SIZE; i++) begin
         if (rs_busy[i] && rs_ready[i] && !rs_is_mem[i] && (!alu_any || age[i] < alu_best)) begin
            alu_any  = 1'b1;
            alu_best = age[i];
            alu_pick = RSW'(i);
         end
      end
   end

   // Oldest memory entry regardless of readiness; it issues only once it is ready,
   // so a younger ready load/store can never overtake it.
   always_comb begin
      mem_any  = 1'b0;
      mem_pick = '0;
      mem_best = '0;
      for (int i = 0; i < RS_SIZE; i++) begin
         if (rs_busy[i] && rs_is_mem[i] && (!mem_any || age[i] < mem_best)) begin
            mem_any  = 1'b1;
            mem_best = age[i];
            mem_pick = RSW'(i);
         end
      end
   end

   assign lsu_any  = mem_any && rs_ready[mem_pick];
   assign alu_load = !alu_valid || alu_ready;
   assign lsu_load = !lsu_valid || lsu_ready;

   // Ack the entries captured into a grant this cycle; nothing is acked under flush or reset.
   always_comb begin
      issue_ack = '0;
      if (reset && !flush) begin
         if (alu_load && alu_any) issue_ack[alu_pick] = 1'b1;
         if (lsu_load && lsu_any) issue_ack[mem_pick] = 1'b1;
      end
   end

   // ALU grant register: load when empty or accepted, otherwise hold; flush drops valid only.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         alu_valid <= 1'b0;
         alu_idx   <= '0;
      end else if (flush) begin
         alu_valid <= 1'b0;
      end else if (alu_load) begin
         alu_valid <= alu_any;
         if (alu_any) alu_idx <= alu_pick;
      end
   end

   // LSU grant register, same hold/flush behaviour as the ALU port.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         lsu_valid <= 1'b0;
         lsu_idx   <= '0;
      end else if (flush) begin
         lsu_valid <= 1'b0;
      end else if (lsu_load) begin
         lsu_valid <= lsu_any;
         if (lsu_any) lsu_idx <= mem_pick;
      end
   end

   assign out_idle = !(|rs_busy) && !alu_valid && !lsu_valid;

endmodule

// File: tb/tb_ysyx_issue_sched.sv
// Scoreboard bench for ysyx_issue_sched. The bench plays the RS: it owns entry state,
// orders entries by dispatch sequence number, predicts acks and queues expected grants.
module tb_ysyx_issue_sched;
   localparam int RS   = 8;
   localparam int ROBW = 4;
   localparam int RSW  = 3;

   logic            clock = 1'b0;
   logic            reset;
   logic [RS-1:0]   rs_busy, rs_ready, rs_is_mem;
   logic [RS*ROBW-1:0] rs_rob_idx;
   logic [ROBW-1:0] rob_head;
   logic            flush, alu_ready, lsu_ready;
   logic            alu_valid, lsu_valid, out_idle;
   logic [RSW-1:0]  alu_idx, lsu_idx;
   logic [RS-1:0]   issue_ack;

   ysyx_issue_sched #(.RS_SIZE(RS), .ROB_SIZE(16)) dut (
      .clock(clock), .reset(reset), .rs_busy(rs_busy), .rs_ready(rs_ready),
      .rs_is_mem(rs_is_mem), .rs_rob_idx(rs_rob_idx), .rob_head(rob_head), .flush(flush),
      .alu_valid(alu_valid), .alu_idx(alu_idx), .alu_ready(alu_ready),
      .lsu_valid(lsu_valid), .lsu_idx(lsu_idx), .lsu_ready(lsu_ready),
      .issue_ack(issue_ack), .out_idle(out_idle));

   always #5 clock = ~clock;

   // model state
   bit            m_busy[RS], m_rdy[RS], m_mem[RS];
   int            m_seq[RS];
   int            m_head, next_seq;
   int            alu_q[$], lsu_q[$];
   int            st_alu = -1, st_lsu = -1;
   logic [RS-1:0] exp_ack = '0;
   int            checks = 0, errors = 0;
   bit            mon_en = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic clr_all();
      for (int i = 0; i < RS; i++) m_busy[i] = 0;
   endtask

   task automatic put(input int i, input int seq, input bit mem, input bit rdy);
      m_busy[i] = 1; m_seq[i] = seq; m_mem[i] = mem; m_rdy[i] = rdy;
   endtask

   // Push model state onto the pins and predict this cycle's acks.
   task automatic drive();
      int a, mo;
      for (int i = 0; i < RS; i++) begin
         rs_busy[i] = m_busy[i];
         if (m_busy[i]) begin
            rs_ready[i] = m_rdy[i];
            rs_is_mem[i] = m_mem[i];
            rs_rob_idx[i*ROBW +: ROBW] = 4'(m_seq[i] % 16);
         end else begin
            rs_ready[i] = 1'($urandom);
            rs_is_mem[i] = 1'($urandom);
            rs_rob_idx[i*ROBW +: ROBW] = 4'($urandom);
         end
      end
      rob_head = 4'(m_head % 16);
      exp_ack = '0;
      if (!flush) begin
         a = -1; mo = -1;
         for (int i = 0; i < RS; i++) begin
            if (m_busy[i] && m_rdy[i] && !m_mem[i] && (a < 0 || m_seq[i] < m_seq[a])) a = i;
            if (m_busy[i] && m_mem[i] && (mo < 0 || m_seq[i] < m_seq[mo])) mo = i;
         end
         if (a >= 0 && (alu_q.size() == 0 || alu_ready)) begin
            exp_ack[a] = 1'b1; st_alu = a;
         end
         if (mo >= 0 && m_rdy[mo] && (lsu_q.size() == 0 || lsu_ready)) begin
            exp_ack[mo] = 1'b1; st_lsu = mo;
         end
      end
   endtask

   // Advance one cycle: acked grants become outstanding, acked entries leave the RS.
   task automatic step();
      @(posedge clock); #1;
      if (st_alu >= 0) alu_q.push_back(st_alu);
      if (st_lsu >= 0) lsu_q.push_back(st_lsu);
      st_alu = -1; st_lsu = -1;
      for (int i = 0; i < RS; i++) if (exp_ack[i]) m_busy[i] = 0;
      exp_ack = '0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin step(); drive(); end
   endtask

   // Monitor: compare outputs mid-cycle against the scoreboard queues.
   always @(negedge clock) begin
      if (mon_en && reset) begin
         bit idle_exp;
         idle_exp = (alu_q.size() == 0) && (lsu_q.size() == 0);
         for (int i = 0; i < RS; i++) if (m_busy[i]) idle_exp = 0;
         chk("issue_ack", int'(issue_ack), int'(exp_ack));
         chk("out_idle", int'(out_idle), int'(idle_exp));
         chk("alu_valid", int'(alu_valid), int'(alu_q.size() != 0));
         chk("lsu_valid", int'(lsu_valid), int'(lsu_q.size() != 0));
         if (alu_q.size() != 0) begin
            if (alu_valid) chk("alu_idx", int'(alu_idx), alu_q[0]);
            if (alu_ready && !flush) void'(alu_q.pop_front());
         end
         if (lsu_q.size() != 0) begin
            if (lsu_valid) chk("lsu_idx", int'(lsu_idx), lsu_q[0]);
            if (lsu_ready && !flush) void'(lsu_q.pop_front());
         end
         if (flush) begin
            alu_q.delete(); lsu_q.delete();
         end
      end
   end

   initial begin
      int minseq;
      // Reset held with every entry busy and ready: no grants, no acks, not idle.
      reset = 1'b0; flush = 1'b0; alu_ready = 1'b1; lsu_ready = 1'b1;
      rob_head = '0;
      for (int i = 0; i < RS; i++) begin
         rs_busy[i] = 1'b1; rs_ready[i] = 1'b1; rs_is_mem[i] = 1'(i % 2);
         rs_rob_idx[i*ROBW +: ROBW] = 4'(i);
      end
      #22;
      chk("rst_alu_valid", int'(alu_valid), 0);
      chk("rst_lsu_valid", int'(lsu_valid), 0);
      chk("rst_alu_idx", int'(alu_idx), 0);
      chk("rst_lsu_idx", int'(lsu_idx), 0);
      chk("rst_issue_ack", int'(issue_ack), 0);
      chk("rst_out_idle_busy", int'(out_idle), 0);
      rs_busy = '0; #1;
      chk("rst_out_idle_empty", int'(out_idle), 1);

      @(posedge clock); #1;
      reset = 1'b1;
      clr_all(); m_head = 0; drive(); mon_en = 1;

      // Age pick: entry 5 (rob 3) before entry 2 (rob 5).
      step(); clr_all(); m_head = 0;
      put(2, 5, 0, 1); put(5, 3, 0, 1); drive();
      idle(4);

      // Wrap: head 14, entry 3 (rob 15) is older than entry 0 (rob 1).
      step(); clr_all(); m_head = 14;
      put(0, 17, 0, 1); put(3, 15, 0, 1); drive();
      idle(4);

      // Memory order: younger ready store waits behind older unready one.
      step(); clr_all(); m_head = 0;
      put(1, 4, 1, 0); put(6, 7, 1, 1); drive();
      idle(3);
      step(); m_rdy[1] = 1; drive();
      idle(4);

      // Hold: ALU stalled for three cycles with new eligibles arriving.
      step(); clr_all(); m_head = 0; alu_ready = 1'b0;
      put(2, 1, 0, 1); drive();
      step(); put(3, 2, 0, 1); put(4, 3, 0, 1); drive();
      idle(3);
      step(); alu_ready = 1'b1; drive();
      idle(4);

      // Flush over pending grants with eligible entries and ready ports.
      step(); clr_all(); m_head = 0; alu_ready = 1'b0; lsu_ready = 1'b0;
      put(0, 1, 0, 1); put(1, 2, 1, 1); drive();
      step(); put(2, 3, 0, 1); put(5, 4, 1, 1); drive();
      step(); flush = 1'b1; alu_ready = 1'b1; lsu_ready = 1'b1; drive();
      step(); drive();
      step(); flush = 1'b0; drive();
      idle(4);

      // Randomized traffic with sequential ROB allocation wrapping the ROB.
      next_seq = 100;
      step(); clr_all(); m_head = next_seq; drive();
      for (int c = 0; c < 3000; c++) begin
         step();
         flush = ($urandom_range(99) < 3);
         alu_ready = ($urandom_range(99) < 70);
         lsu_ready = ($urandom_range(99) < 70);
         for (int i = 0; i < RS; i++)
            if (m_busy[i] && !m_rdy[i] && $urandom_range(99) < 30) m_rdy[i] = 1;
         minseq = next_seq;
         for (int i = 0; i < RS; i++) if (m_busy[i] && m_seq[i] < minseq) minseq = m_seq[i];
         for (int i = 0; i < RS; i++) begin
            if (!m_busy[i] && $urandom_range(99) < 40 && next_seq - minseq <= 12) begin
               put(i, next_seq, $urandom_range(99) < 35, $urandom_range(1) == 1);
               next_seq++;
            end
         end
         m_head = minseq - int'($urandom_range(2));
         drive();
      end

      // Reset asserted with grants outstanding: grants and acks drop at once.
      step(); flush = 1'b0; clr_all(); alu_ready = 1'b0; lsu_ready = 1'b0;
      put(0, next_seq, 0, 1); put(1, next_seq + 1, 1, 1);
      m_head = next_seq; next_seq += 2; drive();
      step(); put(2, next_seq, 0, 1); next_seq++; drive();
      step();
      mon_en = 0; reset = 1'b0; #1;
      chk("midrst_alu_valid", int'(alu_valid), 0);
      chk("midrst_lsu_valid", int'(lsu_valid), 0);
      chk("midrst_issue_ack", int'(issue_ack), 0);
      alu_q.delete(); lsu_q.delete(); st_alu = -1; st_lsu = -1; exp_ack = '0;
      clr_all();
      @(posedge clock); #1;
      reset = 1'b1; alu_ready = 1'b1; lsu_ready = 1'b1;
      m_head = next_seq; drive(); mon_en = 1;
      idle(3);

      @(posedge clock); #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
